// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl -- multi-cycle wide adder built around one N-bit slice adder.
//
// Computes an (N*WORDS)-bit sum by passing one N-bit slice per clock through a
// single shared adder, least-significant slice first. The carry between
// slices is held in a register, so an operation takes WORDS cycles. This
// trades latency for a much narrower adder.
//
// Optional feature macro: ADD_SEQ_SUB_EN
//   defined   : adds input 'sub'. When it is captured as 1, the result is
//               A-B mod 2^(N*WORDS) and Cout=1 means no borrow (A>=B).
//   undefined : add only. No 'sub' port and no inversion logic.
//
// Parameters
//   N      slice width in bits (one adder pass)
//   WORDS  slices per operation (>=1); operand width is N*WORDS
//
// Ports
//   clk    in   1        clock; all state changes on its rising edge
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request, sampled only while idle
//   sub    in   1        subtract select (ADD_SEQ_SUB_EN builds only)
//   A      in   N*WORDS  operand A, captured on an accepted start
//   B      in   N*WORDS  operand B, captured on an accepted start
//   Sum    out  N*WORDS  result register, written one slice per cycle
//   Cout   out  1        carry out of the top slice, held until the next start
//   busy   out  1        operation in progress
//   done   out  1        one-cycle completion pulse

// Plain N+2 bit adder. The caller packs a carry into the LSB of both inputs.
module adder_n #(
    parameter int W = 34
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);
    assign res = a + b;
endmodule

module adder_seq_ctrl #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef ADD_SEQ_SUB_EN
    input  logic               sub,
`endif
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic [N*WORDS-1:0] Sum,
    output logic               Cout,
    output logic               busy,
    output logic               done
);
    localparam int            W    = N * WORDS;
    localparam int            IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;

    // Operand registers. They are pure data, so they carry no reset.
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
`ifdef ADD_SEQ_SUB_EN
    logic          sub_q;
`endif

    logic          accept;
    logic          init_carry;
    logic [N-1:0]  a_slice;
    logic [N-1:0]  b_slice;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    logic [N+1:0]  add_a;
    logic [N+1:0]  add_b;
    logic [N+1:0]  add_res;
    logic          unused_lsb;

    assign accept = (state == IDLE) && start;

`ifdef ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so the first slice starts with carry set.
    assign init_carry = sub;
    assign b_slice    = opb[idx*N +: N] ^ {N{sub_q}};
`else
    assign init_carry = 1'b0;
    assign b_slice    = opb[idx*N +: N];
`endif

    assign a_slice = opa[idx*N +: N];

    // The carry goes in the LSB of both inputs. carry+carry at bit 0 then
    // produces exactly one carry into bit 1, so the real slice sum is
    // res[N:1] and the slice carry-out is res[N+1]. Bit 0 is always 0.
    assign add_a = {1'b0, a_slice, carry};
    assign add_b = {1'b0, b_slice, carry};

    adder_n #(
        .W   (N + 2)
    ) u_adder (
        .a   (add_a),
        .b   (add_b),
        .res (add_res)
    );

    assign slice_sum  = add_res[N:1];
    assign slice_cout = add_res[N+1];
    assign unused_lsb = add_res[0];

    // Operands are captured once per accepted start. A and B may change
    // freely while the operation runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa   <= A;
            opb   <= B;
`ifdef ADD_SEQ_SUB_EN
            sub_q <= sub;
`endif
        end
    end

    // Control FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        idx   <= '0;
                        carry <= init_carry;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    Sum[idx*N +: N] <= slice_sum;
                    carry           <= slice_cout;
                    if (idx == LAST) begin
                        // Wrap idx to 0 so it never goes past WORDS-1.
                        state <= IDLE;
                        idx   <= '0;
                        Cout  <= slice_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl. Main instance is N=8, WORDS=4. A second
// instance with N=8, WORDS=1 covers the single-slice case. Expected results
// are queued when a start is accepted and popped when done is seen.
module tb_adder_seq_ctrl;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub_v;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    logic         start1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [N-1:0] sum1;
    logic         cout1;
    logic         busy1;
    logic         done1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;

    adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub_v),
`endif
        .A     (a_in),
        .B     (b_in),
        .Sum   (sum),
        .Cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    adder_seq_ctrl #(.N(N), .WORDS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
`ifdef ADD_SEQ_SUB_EN
        .sub   (1'b0),
`endif
        .A     (a1),
        .B     (b1),
        .Sum   (sum1),
        .Cout  (cout1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: tracks when a start is accepted and queues the result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            sb.delete();
        end else begin
            cyc++;
            if (!m_busy) begin
                if (start) begin
                    logic [W:0]   t;
                    logic [W-1:0] bb;
                    exp_t         e;
                    bb     = sub_v ? ~b_in : b_in;
                    t      = {1'b0, a_in} + {1'b0, bb} + (W+1)'(sub_v);
                    e.sum  = t[W-1:0];
                    e.cout = t[W];
                    e.cyc  = cyc + WORDS;
                    sb.push_back(e);
                    m_busy = 1'b1;
                    m_cnt  = WORDS;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_busy = 1'b0;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(busy), 64'(m_busy));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", 64'(sum), 64'(e.sum));
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    last_sum  = e.sum;
                    last_cout = e.cout;
                end
            end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                chk("done_timeout", 64'(done), 64'(1));
                void'(sb.pop_front());
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        sub_v = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        repeat (WORDS + 1) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        sub_v  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        #3;
        rst_n = 1'b0;
        #20;
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Carry out of the bottom slice only.
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        // Carry ripples through every slice.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sum_hold", 64'(sum), 64'(last_sum));
        chk("cout_hold", 64'(cout), 64'(last_cout));

        // Hold start through RUN while A/B change, then leave start high in
        // the done cycle so a second operation follows back to back.
        @(posedge clk);
        #1;
        a_in  = 32'h1234_5678;
        b_in  = 32'h0FED_CBA9;
        start = 1'b1;
        repeat (WORDS) begin
            @(posedge clk);
            #1;
            a_in = $urandom;
            b_in = $urandom;
        end
        a_in = 32'h8000_0000;
        b_in = 32'h8000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (WORDS + 2) @(posedge clk);

        // Asynchronous reset while idx==2.
        @(posedge clk);
        #1;
        a_in  = 32'hAAAA_AAAA;
        b_in  = 32'h5555_5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (WORDS + 4) @(posedge clk);
        #1;
        chk("post_abort_sum", 64'(sum), 64'(0));

        // Random additions.
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

`ifdef ADD_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b1);
        run_op(32'd7, 32'd5, 1'b1);
        run_op(32'd9, 32'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
`endif

        // Single-slice instance: done one cycle after the start edge.
        @(posedge clk);
        #1;
        a1     = 8'hFF;
        b1     = 8'h02;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1     = 8'h00;
        b1     = 8'h00;
        chk("w1_busy", 64'(busy1), 64'(1));
        chk("w1_early_done", 64'(done1), 64'(0));
        @(posedge clk);
        #1;
        chk("w1_done", 64'(done1), 64'(1));
        chk("w1_sum", 64'(sum1), 64'(8'h01));
        chk("w1_cout", 64'(cout1), 64'(1));
        chk("w1_busy_end", 64'(busy1), 64'(0));
        @(posedge clk);
        #1;
        chk("w1_done_clear", 64'(done1), 64'(0));
        chk("w1_sum_hold", 64'(sum1), 64'(8'h01));

        repeat (WORDS + 2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
